// File: rtl/load_store_unit.sv
// Load/store unit: turns byte-addressed loads/stores into word-wide memory
// accesses, with read-modify-write for sub-word stores and local load extension.
module load_store_unit #(
  parameter int INDEX_W = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic        resp_error,
  output logic [31:0] resp_rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_write_data,
  output logic        mem_read,
  output logic        mem_write,
  output logic [2:0]  mem_size,
  input  logic [31:0] mem_read_data
);

  typedef enum logic [2:0] {IDLE, RD, CAP, WR, RESP} state_t;

  state_t             state;
  logic               write_q;
  logic [2:0]         funct_q;
  logic [1:0]         lane_q;
  logic [INDEX_W-1:0] index_q;
  logic [31:0]        wdata_q;

  logic        req_legal;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_val;
  logic [31:0] merge_val;

  // Address bits above the word index are intentionally dropped so the index wraps.
  logic unused_addr_bits;
  assign unused_addr_bits = ^req_addr[31:INDEX_W+2];

  always_comb begin
    req_legal = 1'b0;
    case (req_funct)
      3'b001, 3'b101: req_legal = 1'b1;
      3'b010, 3'b110: req_legal = ~req_addr[0];
      3'b011:         req_legal = (req_addr[1:0] == 2'b00);
      default:        req_legal = 1'b0;
    endcase
    if (req_write && req_funct[2])
      req_legal = 1'b0;
  end

  always_comb begin
    byte_sel = mem_read_data[{lane_q, 3'b000} +: 8];
    half_sel = lane_q[1] ? mem_read_data[31:16] : mem_read_data[15:0];
    case (funct_q[1:0])
      2'b01:   load_val = {{24{byte_sel[7] & ~funct_q[2]}}, byte_sel};
      2'b10:   load_val = {{16{half_sel[15] & ~funct_q[2]}}, half_sel};
      default: load_val = mem_read_data;
    endcase
    // Only the addressed lane is replaced; every other byte of the word survives.
    merge_val = mem_read_data;
    if (funct_q[1:0] == 2'b01)
      merge_val[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
    else if (lane_q[1])
      merge_val[31:16] = wdata_q[15:0];
    else
      merge_val[15:0] = wdata_q[15:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      write_q        <= 1'b0;
      funct_q        <= 3'b000;
      lane_q         <= 2'b00;
      index_q        <= '0;
      wdata_q        <= 32'h0;
      resp_error     <= 1'b0;
      resp_rdata     <= 32'h0;
      mem_write_data <= 32'h0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          write_q    <= req_write;
          funct_q    <= req_funct;
          lane_q     <= req_addr[1:0];
          index_q    <= req_addr[INDEX_W+1:2];
          wdata_q    <= req_wdata;
          resp_rdata <= 32'h0;
          resp_error <= ~req_legal;
          if (req_write)
            mem_write_data <= req_wdata;
          if (!req_legal)
            state <= RESP;
          else if (req_write && req_funct == 3'b011)
            state <= WR;
          else
            state <= RD;
        end
        RD:  state <= CAP;
        CAP: begin
          if (write_q) begin
            mem_write_data <= merge_val;
            state          <= WR;
          end else begin
            resp_rdata <= load_val;
            state      <= RESP;
          end
        end
        WR:      state <= RESP;
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Strobes come straight from the state register so reset kills them at once.
  assign req_ready  = (state == IDLE);
  assign mem_read   = (state == RD);
  assign mem_write  = (state == WR);
  assign resp_valid = (state == RESP);
  assign mem_addr   = {{(32-INDEX_W){1'b0}}, index_q};
  assign mem_size   = 3'b011;

endmodule
